spi_transmitter: RTL and testbench



---
 rtl/spi_transmitter.sv | 136 +++++++++++++
 tb/tb_spi_transmitter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transmitter.sv
// SPI mode-0 controller-side transmitter.
// Serialises a WIDTH-bit word MSB-first on mosi, generating cs and sck from sys_clk.
//
// state | meaning
// IDLE  | waiting for a word, tx_ready high
// LEAD  | cs low, first bit on mosi, sck low before the first rising edge
// HIGH  | sck high, receiver samples mosi
// LOW   | sck low, next bit already on mosi
// GAP   | cs high recovery time before the next frame
module spi_transmitter #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             cs,
    output logic             sck,
    output logic             mosi,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]       GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] BITS     = CNT_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t             state;
    logic [7:0]         div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               div_end;

    // Phase timer terminal count; the divider restarts from 0 on every phase change.
    assign div_end  = (div_cnt == DIV_LAST);

    // Only an idle transmitter can take a new word; anything offered while busy is dropped.
    assign tx_ready = (state == S_IDLE);

    // Frame sequencer: all outputs registered, one phase change per divider terminal count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cs      <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        mosi    <= tx_data[WIDTH-1];
                        cs      <= 1'b0;
                        sck     <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        state   <= S_LOW;
                        // After the last rising edge mosi keeps bit 0 until cs rises.
                        if (bit_cnt != BITS) begin
                            shreg <= shreg << 1;
                            mosi  <= shreg[WIDTH-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_LOW: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BITS) begin
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_GAP;
                        end else begin
                            sck     <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= S_HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transmitter.sv
// Testbench for spi_transmitter: default instance plus a CLK_DIV=1/CS_GAP=1 instance,
// each watched by a receiver-style reference model that decodes frames from the pins.
module tb_spi_transmitter;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic        rst_a   [2];
    logic        valid_a [2];
    logic [15:0] data_a  [2];

    logic ready0, cs0, sck0, mosi0, busy0, done0;
    logic ready1, cs1, sck1, mosi1, busy1, done1;
    logic [5:0] o0, o1;
    assign o0 = {ready0, cs0, sck0, mosi0, busy0, done0};
    assign o1 = {ready1, cs1, sck1, mosi1, busy1, done1};

    spi_transmitter #(.WIDTH(16), .CLK_DIV(2), .CS_GAP(2)) dut0 (
        .sys_clk (sys_clk),
        .rst     (rst_a[0]),
        .tx_data (data_a[0]),
        .tx_valid(valid_a[0]),
        .tx_ready(ready0),
        .cs      (cs0),
        .sck     (sck0),
        .mosi    (mosi0),
        .busy    (busy0),
        .done    (done0)
    );

    spi_transmitter #(.WIDTH(16), .CLK_DIV(1), .CS_GAP(1)) dut1 (
        .sys_clk (sys_clk),
        .rst     (rst_a[1]),
        .tx_data (data_a[1]),
        .tx_valid(valid_a[1]),
        .tx_ready(ready1),
        .cs      (cs1),
        .sck     (sck1),
        .mosi    (mosi1),
        .busy    (busy1),
        .done    (done1)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] last_bits  [2];
    int          last_low   [2];
    int          last_edges [2];
    int          frames     [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs(input int k);
        return (k == 0) ? o0 : o1;
    endfunction

    // Reference model: predicts accepts from the frame-length arithmetic and decodes
    // each frame like a receiver would (sample mosi on sck rise while cs is low).
    task automatic monitor(input int k, input int d, input int g);
        logic [15:0] q[$];
        logic [15:0] bits = '0;
        logic [15:0] expw;
        logic [5:0]  o;
        logic        prev_cs = 1'b1, prev_sck = 1'b0, rst_d = 1'b0;
        logic        exp_ready, rose;
        int          n = 0, next_ok = 0, low = 0, edges = 0;
        forever begin
            @(negedge sys_clk);
            n++;
            o = outs(k);
            rose = o[4] && !prev_cs;
            exp_ready = (n >= next_ok);
            check($sformatf("ready%0d", k), {31'd0, o[5]}, {31'd0, exp_ready});
            check($sformatf("busy%0d", k), {31'd0, o[1]}, {31'd0, !exp_ready});
            check($sformatf("done%0d", k), {31'd0, o[0]}, {31'd0, rose && !rst_d});
            if (o[4]) begin
                check($sformatf("sck_idle%0d", k), {31'd0, o[3]}, 32'd0);
                check($sformatf("mosi_idle%0d", k), {31'd0, o[2]}, 32'd0);
            end else begin
                if (prev_cs) begin
                    low = 0; edges = 0; bits = '0;
                end
                low++;
                if (o[3] && !prev_sck) begin
                    bits = {bits[14:0], o[2]};
                    edges++;
                end
            end
            if (rose && !rst_d) begin
                if (q.size() == 0) begin
                    check($sformatf("unexpected_frame%0d", k), 32'd1, 32'd0);
                end else begin
                    expw = q.pop_front();
                    check($sformatf("frame_word%0d", k), {16'd0, bits}, {16'd0, expw});
                    check($sformatf("frame_edges%0d", k), edges, 16);
                    check($sformatf("cs_low%0d", k), low, d * 33);
                end
                last_bits[k]  = bits;
                last_low[k]   = low;
                last_edges[k] = edges;
                frames[k]     = frames[k] + 1;
            end
            if (rst_a[k]) begin
                q.delete();
                next_ok = n + 1;
            end else if (valid_a[k] && exp_ready) begin
                q.push_back(data_a[k]);
                next_ok = n + 1 + d * 33 + g;
            end
            rst_d    = rst_a[k];
            prev_cs  = o[4];
            prev_sck = o[3];
        end
    endtask

    task automatic wait_ready(input int k);
        int t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (!outs(k)[5] && t < 500);
        if (t >= 500) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int k, input logic [15:0] d);
        @(posedge sys_clk); #1;
        data_a[k]  = d;
        valid_a[k] = 1'b1;
        wait_ready(k);
        @(posedge sys_clk); #1;
        valid_a[k] = 1'b0;
        data_a[k]  = 16'($urandom);
    endtask

    task automatic wait_frame(input int k, input int f0);
        int t = 0;
        while (frames[k] == f0 && t < 300) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 300) check("frame_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int          k;
        logic [15:0] data;
        logic [15:0] exp_word;
        int          exp_low;
        int          exp_edges;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, f0, t, nr;
        logic [5:0] o;

        vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 66, 16};
        vecs[1] = '{0, 16'h8001, 16'h8001, 66, 16};
        vecs[2] = '{0, 16'h0000, 16'h0000, 66, 16};
        vecs[3] = '{0, 16'hFFFF, 16'hFFFF, 66, 16};
        vecs[4] = '{1, 16'h5555, 16'h5555, 33, 16};
        vecs[5] = '{1, 16'h8001, 16'h8001, 33, 16};

        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b1; valid_a[k] = 1'b0; data_a[k] = '0;
            frames[k] = 0; last_bits[k] = '0; last_low[k] = 0; last_edges[k] = 0;
        end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cs",    {31'd0, cs0},    32'd1);
        check("rst_sck",   {31'd0, sck0},   32'd0);
        check("rst_mosi",  {31'd0, mosi0},  32'd0);
        check("rst_busy",  {31'd0, busy0},  32'd0);
        check("rst_done",  {31'd0, done0},  32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd1);
        check("rst_cs1",   {31'd0, cs1},    32'd1);
        @(posedge sys_clk); #1;
        rst_a[0] = 1'b0; rst_a[1] = 1'b0;
        fork
            monitor(0, 2, 2);
            monitor(1, 1, 1);
        join_none

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            f0 = frames[vecs[i].k];
            send(vecs[i].k, vecs[i].data);
            wait_frame(vecs[i].k, f0);
            check($sformatf("vec%0d_word", i), {16'd0, last_bits[vecs[i].k]}, {16'd0, vecs[i].exp_word});
            check($sformatf("vec%0d_low", i), last_low[vecs[i].k], vecs[i].exp_low);
            check($sformatf("vec%0d_edges", i), last_edges[vecs[i].k], vecs[i].exp_edges);
        end

        // back-to-back with tx_valid held
        wait_ready(0);
        @(posedge sys_clk); #1;
        data_a[0] = 16'hFFFF; valid_a[0] = 1'b1;
        wait_ready(0);
        @(posedge sys_clk); #1;
        a1 = cyc;
        data_a[0] = 16'h0000;
        f0 = frames[0];
        wait_ready(0);
        @(posedge sys_clk); #1;
        a2 = cyc;
        valid_a[0] = 1'b0;
        check("b2b_spacing", a2 - a1, 69);
        wait_frame(0, f0 + 1);
        check("b2b_second_word", {16'd0, last_bits[0]}, 32'h0);

        // offers while busy are ignored; captured word is not disturbed
        wait_ready(0);
        f0 = frames[0];
        send(0, 16'h1234);
        valid_a[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_a[0] = 16'($urandom);
            @(posedge sys_clk); #1;
        end
        valid_a[0] = 1'b0;
        wait_frame(0, f0);
        check("busy_ignore_word", {16'd0, last_bits[0]}, 32'h1234);
        repeat (4) @(negedge sys_clk);
        check("busy_ignore_no_extra", frames[0], f0 + 1);

        // reset after the 5th sck rising edge
        wait_ready(0);
        f0 = frames[0];
        send(0, 16'hCAFE);
        nr = 0; t = 0;
        while (nr < 5 && t < 200) begin
            @(negedge sys_clk);
            if (sck0) nr++;
            while (sck0 && t < 200) begin @(negedge sys_clk); t++; end
            t++;
        end
        if (t >= 200) check("rise5_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1;
        rst_a[0] = 1'b1;
        @(posedge sys_clk); #1;
        rst_a[0] = 1'b0;
        @(negedge sys_clk);
        o = o0;
        check("abort_cs",   {31'd0, o[4]}, 32'd1);
        check("abort_sck",  {31'd0, o[3]}, 32'd0);
        check("abort_mosi", {31'd0, o[2]}, 32'd0);
        check("abort_busy", {31'd0, o[1]}, 32'd0);
        check("abort_done", {31'd0, o[0]}, 32'd0);
        repeat (3) @(negedge sys_clk);
        check("abort_no_frame", frames[0], f0);
        send(0, 16'h00FF);
        wait_frame(0, f0);
        check("after_abort_word", {16'd0, last_bits[0]}, 32'h00FF);

        // reset and valid on the same edge: no accept
        wait_ready(0);
        @(posedge sys_clk); #1;
        rst_a[0] = 1'b1; valid_a[0] = 1'b1; data_a[0] = 16'h7777;
        @(posedge sys_clk); #1;
        rst_a[0] = 1'b0; valid_a[0] = 1'b0;
        @(negedge sys_clk);
        check("rst_wins_busy", {31'd0, busy0}, 32'd0);
        check("rst_wins_cs",   {31'd0, cs0},   32'd1);

        // randomized traffic on both instances
        for (int i = 0; i < 30; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            f0 = frames[k];
            repeat ($urandom_range(0, 5)) @(posedge sys_clk);
            send(k, 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                valid_a[k] = 1'b1;
                repeat ($urandom_range(1, 10)) begin
                    data_a[k] = 16'($urandom);
                    @(posedge sys_clk); #1;
                end
                valid_a[k] = 1'b0;
            end
            wait_frame(k, f0);
        end

        repeat (80) @(posedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
